// File: rtl/sdr_bridge_arbiter.sv
// rtl/sdr_bridge_arbiter.sv - round-robin arbiter in front of the single SDRAM burst bridge
//
// Purpose:
//    Grants one client burst at a time (round-robin starting at rr), issues the
//    bridge start pulse with stable address/length/payload, waits for the
//    matching end pulse or a watchdog timeout, then reports completion (and read
//    data) back to the owning client.
//
// Ports:
//    sdr_clk, sdr_reset          clock, asynchronous active-high reset
//    req_valid/req_ready         per-client request handshake (ready is one-hot or zero)
//    req_write/addr/nelems/wdata per-client request fields, client i in slice i
//    done, done_err              one-cycle completion pulse to owner, error qualifier
//    rdata, rdata_valid, rdata_id captured read burst, pulse and owner
//    sdr_*                       bridge side: address/length/start/end/data
//    busy                        high whenever a transaction is in flight

module sdr_bridge_arbiter #(
   parameter int NREQ        = 2,
   parameter int DATA_W      = 2048,
   parameter int MAX_NELEMS  = 64,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                       sdr_clk,
   input  logic                       sdr_reset,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0]            req_write,
   input  logic [NREQ*32-1:0]         req_addr,
   input  logic [NREQ*30-1:0]         req_nelems,
   input  logic [NREQ*DATA_W-1:0]     req_wdata,
   output logic [NREQ-1:0]            done,
   output logic                       done_err,
   output logic [DATA_W-1:0]          rdata,
   output logic                       rdata_valid,
   output logic [$clog2(NREQ)-1:0]    rdata_id,
   output logic [31:0]                sdr_baseaddr,
   output logic [29:0]                sdr_nelems,
   output logic                       sdr_readstart,
   output logic                       sdr_writestart,
   output logic [DATA_W-1:0]          sdr_writedata,
   input  logic                       sdr_readend,
   input  logic                       sdr_writeend,
   input  logic [DATA_W-1:0]          sdr_readdata,
   output logic                       busy
);

   localparam int IDW = $clog2(NREQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
   localparam logic [29:0]    MAXN    = 30'(MAX_NELEMS);
   localparam logic [23:0]    TO_LAST = 24'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   logic [IDW-1:0]      r_rr;
   logic [IDW-1:0]      r_id;
   logic                r_write;
   logic [23:0]         r_cnt;
   logic [31:0]         r_baseaddr;
   logic [29:0]         r_nelems;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_readstart;
   logic                r_writestart;
   logic [NREQ-1:0]     r_done;
   logic                r_done_err;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_rdata_valid;
   logic [IDW-1:0]      r_rdata_id;
   logic                r_busy;

   logic                w_found;
   logic [IDW-1:0]      w_gid;
   logic [NREQ-1:0]     w_ready;
   logic                w_sel_write;
   logic [31:0]         w_sel_addr;
   logic [29:0]         w_sel_nelems;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_end_match;
   logic [IDW-1:0]      w_rr_next;

   // Client index k positions after base, wrapping at NREQ.
   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   // Walk from the farthest candidate back to rr so the closest valid client wins.
   always_comb begin
      w_found = 1'b0;
      w_gid   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[rr_index(r_rr, k)]) begin
            w_found = 1'b1;
            w_gid   = rr_index(r_rr, k);
         end
      end
   end

   // Ready is held low during reset so every output reads zero while it is asserted.
   always_comb begin
      w_ready = '0;
      if (r_state == S_IDLE && w_found && !sdr_reset) begin
         w_ready[w_gid] = 1'b1;
      end
   end

   assign w_sel_write  = req_write[w_gid];
   assign w_sel_addr   = req_addr[int'(w_gid) * 32 +: 32];
   assign w_sel_nelems = req_nelems[int'(w_gid) * 30 +: 30];
   assign w_sel_wdata  = req_wdata[int'(w_gid) * DATA_W +: DATA_W];
   assign w_end_match  = r_write ? sdr_writeend : sdr_readend;
   assign w_rr_next    = (w_gid == LAST_ID) ? '0 : w_gid + IDW'(1);

   always_ff @(posedge sdr_clk or posedge sdr_reset) begin
      if (sdr_reset) begin
         r_state       <= S_IDLE;
         r_rr          <= '0;
         r_id          <= '0;
         r_write       <= 1'b0;
         r_cnt         <= '0;
         r_baseaddr    <= '0;
         r_nelems      <= '0;
         r_wdata       <= '0;
         r_readstart   <= 1'b0;
         r_writestart  <= 1'b0;
         r_done        <= '0;
         r_done_err    <= 1'b0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_rdata_id    <= '0;
         r_busy        <= 1'b0;
      end else begin
         // Single-cycle pulses default low; the transition into ISSUE/DONE raises them.
         r_readstart   <= 1'b0;
         r_writestart  <= 1'b0;
         r_done        <= '0;
         r_done_err    <= 1'b0;
         r_rdata_valid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_id    <= w_gid;
                  r_write <= w_sel_write;
                  r_wdata <= w_sel_wdata;
                  r_rr    <= w_rr_next;
                  r_busy  <= 1'b1;
                  if (w_sel_nelems == 30'd0) begin
                     // Empty burst: complete immediately without touching the bridge.
                     r_state       <= S_DONE;
                     r_done[w_gid] <= 1'b1;
                  end else if (w_sel_nelems > MAXN) begin
                     r_state       <= S_DONE;
                     r_done[w_gid] <= 1'b1;
                     r_done_err    <= 1'b1;
                  end else begin
                     r_state      <= S_ISSUE;
                     r_readstart  <= ~w_sel_write;
                     r_writestart <= w_sel_write;
                     r_baseaddr   <= w_sel_addr;
                     r_nelems     <= w_sel_nelems;
                  end
               end
            end

            S_ISSUE: begin
               r_state <= S_WAIT;
            end

            S_WAIT: begin
               // A matching end in the final timeout cycle still counts as success.
               if (w_end_match) begin
                  r_state      <= S_DONE;
                  r_done[r_id] <= 1'b1;
                  r_baseaddr   <= '0;
                  r_nelems     <= '0;
                  if (!r_write) begin
                     r_rdata       <= sdr_readdata;
                     r_rdata_valid <= 1'b1;
                     r_rdata_id    <= r_id;
                  end
               end else if (r_cnt == TO_LAST) begin
                  r_state      <= S_DONE;
                  r_done[r_id] <= 1'b1;
                  r_done_err   <= 1'b1;
                  r_baseaddr   <= '0;
                  r_nelems     <= '0;
               end else begin
                  r_cnt <= r_cnt + 24'd1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready      = w_ready;
   assign done           = r_done;
   assign done_err       = r_done_err;
   assign rdata          = r_rdata;
   assign rdata_valid    = r_rdata_valid;
   assign rdata_id       = r_rdata_id;
   assign sdr_baseaddr   = r_baseaddr;
   assign sdr_nelems     = r_nelems;
   assign sdr_readstart  = r_readstart;
   assign sdr_writestart = r_writestart;
   assign sdr_writedata  = r_wdata;
   assign busy           = r_busy;

endmodule

// File: tb/tb_sdr_bridge_arbiter.sv
// tb/tb_sdr_bridge_arbiter.sv - self-checking bench for sdr_bridge_arbiter

module tb_sdr_bridge_arbiter;

   localparam int NREQ = 2;
   localparam int DW   = 2048;
   localparam int MAXN = 64;
   localparam int TO   = 100;

   logic                 sdr_clk = 1'b0;
   logic                 sdr_reset = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_write = '0;
   logic [NREQ*32-1:0]   req_addr = '0;
   logic [NREQ*30-1:0]   req_nelems = '0;
   logic [NREQ*DW-1:0]   req_wdata = '0;
   logic [NREQ-1:0]      done;
   logic                 done_err;
   logic [DW-1:0]        rdata;
   logic                 rdata_valid;
   logic [0:0]           rdata_id;
   logic [31:0]          sdr_baseaddr;
   logic [29:0]          sdr_nelems;
   logic                 sdr_readstart;
   logic                 sdr_writestart;
   logic [DW-1:0]        sdr_writedata;
   logic                 sdr_readend = 1'b0;
   logic                 sdr_writeend = 1'b0;
   logic [DW-1:0]        sdr_readdata = '0;
   logic                 busy;

   sdr_bridge_arbiter #(
      .NREQ(NREQ), .DATA_W(DW), .MAX_NELEMS(MAXN), .TIMEOUT_CYC(TO)
   ) dut (
      .sdr_clk(sdr_clk), .sdr_reset(sdr_reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_nelems(req_nelems), .req_wdata(req_wdata),
      .done(done), .done_err(done_err), .rdata(rdata), .rdata_valid(rdata_valid),
      .rdata_id(rdata_id), .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems),
      .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
      .sdr_writedata(sdr_writedata), .sdr_readend(sdr_readend),
      .sdr_writeend(sdr_writeend), .sdr_readdata(sdr_readdata), .busy(busy)
   );

   always #5 sdr_clk = ~sdr_clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [NREQ-1:0] last_hs = '0;

   // Transaction-level reference: one in-flight request described by its accept
   // cycle and the cycle its completion is shown (-1 while still undecided).
   bit              m_act = 0;
   bit              m_legal = 0;
   bit              m_wr = 0;
   bit              m_err = 0;
   bit              m_rdok = 0;
   int              m_acc = 0;
   int              m_done_at = -1;
   int              m_id = 0;
   int              m_rr = 0;
   logic [31:0]     m_addr = '0;
   logic [29:0]     m_nel = '0;
   logic [DW-1:0]   m_wdata = '0;
   logic [DW-1:0]   m_rdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got[63:0] %0h expected[63:0] %0h", name, cyc, act[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [DW-1:0] rand_wide();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic int model_grant();
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] model_ready();
      logic [NREQ-1:0] r;
      int g;
      r = '0;
      if (!m_act) begin
         g = model_grant();
         if (g >= 0) r[g] = 1'b1;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_act = 0; m_rr = 0; m_rdata = '0; m_done_at = -1;
   endtask

   // Advance the reference over the clock edge that ends cycle cyc.
   task automatic model_step();
      int c, g;
      c = cyc;
      if (m_act) begin
         if (m_done_at == c) begin
            m_act = 0;
         end else if (m_done_at < 0 && c >= m_acc + 2) begin
            if (m_wr ? sdr_writeend : sdr_readend) begin
               m_done_at = c + 1; m_err = 0; m_rdok = !m_wr;
               if (!m_wr) m_rdata = sdr_readdata;
            end else if (c - (m_acc + 2) == TO - 1) begin
               m_done_at = c + 1; m_err = 1; m_rdok = 0;
            end
         end
      end else begin
         g = model_grant();
         if (g >= 0) begin
            m_act = 1; m_acc = c; m_id = g; m_rr = (g + 1) % NREQ;
            m_wr = req_write[g];
            m_addr = req_addr[32*g +: 32];
            m_nel = req_nelems[30*g +: 30];
            m_wdata = req_wdata[DW*g +: DW];
            m_rdok = 0;
            m_legal = (m_nel != 0) && (m_nel <= 30'(MAXN));
            if (m_legal) begin
               m_done_at = -1;
            end else begin
               m_done_at = c + 1; m_err = (m_nel != 0);
            end
         end
      end
   endtask

   task automatic check_outputs();
      int n;
      bit in_iw, is_done;
      logic [NREQ-1:0] e_done;
      n = cyc;
      in_iw = m_act && m_legal && (n > m_acc) && (m_done_at < 0 || n < m_done_at);
      is_done = m_act && (n == m_done_at);
      e_done = '0;
      if (is_done) e_done[m_id] = 1'b1;
      chk("busy", busy, m_act);
      chk("sdr_readstart", sdr_readstart, m_act && m_legal && !m_wr && n == m_acc + 1);
      chk("sdr_writestart", sdr_writestart, m_act && m_legal && m_wr && n == m_acc + 1);
      chk("sdr_baseaddr", sdr_baseaddr, in_iw ? m_addr : 32'd0);
      chk("sdr_nelems", sdr_nelems, in_iw ? m_nel : 30'd0);
      if (in_iw && m_wr) chk_wide("sdr_writedata", sdr_writedata, m_wdata);
      chk("done", done, e_done);
      chk("done_err", done_err, is_done && m_err);
      chk("rdata_valid", rdata_valid, is_done && m_rdok);
      if (is_done && m_rdok) chk("rdata_id", rdata_id, m_id);
      chk_wide("rdata", rdata, m_rdata);
   endtask

   // Called at a falling edge with inputs already set for this cycle.
   task automatic step();
      #1;
      chk("req_ready", req_ready, model_ready());
      last_hs = req_ready & req_valid;
      @(posedge sdr_clk);
      model_step();
      cyc++;
      @(negedge sdr_clk);
      check_outputs();
   endtask

   task automatic rand_bridge(input int pct_r, input int pct_w);
      sdr_readend = ($urandom % 100) < pct_r;
      sdr_writeend = ($urandom % 100) < pct_w;
      sdr_readdata = rand_wide();
   endtask

   task automatic drain(input int limit);
      int k;
      k = 0;
      while (m_act && k < limit) begin
         rand_bridge(25, 25);
         step();
         k++;
      end
      sdr_readend = 0; sdr_writeend = 0;
      chk("drain_bound", m_act, 0);
   endtask

   task automatic reset_literals();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_rdata_valid", rdata_valid, 0);
      chk("rst_rdata_id", rdata_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_readstart", sdr_readstart, 0);
      chk("rst_writestart", sdr_writestart, 0);
      chk("rst_baseaddr", sdr_baseaddr, 0);
      chk("rst_nelems", sdr_nelems, 0);
      chk_wide("rst_writedata", sdr_writedata, '0);
      chk_wide("rst_rdata", rdata, '0);
   endtask

   task automatic randomize_client(input int i);
      int r;
      req_valid[i] = ($urandom % 4) != 0;
      req_write[i] = $urandom % 2;
      req_addr[32*i +: 32] = $urandom;
      r = $urandom % 10;
      if (r == 0)      req_nelems[30*i +: 30] = 30'd0;
      else if (r == 1) req_nelems[30*i +: 30] = 30'(65 + $urandom % 100);
      else if (r == 2) req_nelems[30*i +: 30] = 30'($urandom);
      else             req_nelems[30*i +: 30] = 30'(1 + $urandom % 64);
      req_wdata[DW*i +: DW] = rand_wide();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit cycle %0d: got timeout expected finish", cyc);
      $fatal(1, "time limit");
   end

   initial begin
      int acc, done_c, rs_cnt, rs_cyc, rv_cnt, dn_cnt, rv_at_done;
      logic [NREQ-1:0] done_val;
      logic err_obs, id_obs;
      logic [DW-1:0] rd_obs, pat;
      logic [31:0] ba_obs;
      logic [29:0] ne_obs;
      logic [NREQ-1:0] gq[$];

      pat = {256{8'hA5}};
      ba_obs = '1; ne_obs = '0; done_val = '0; err_obs = 1'bx; id_obs = 1'bx; rd_obs = '0;

      // Power-on reset.
      sdr_reset = 1'b1;
      req_valid = 2'b11;
      @(posedge sdr_clk);
      @(negedge sdr_clk);
      reset_literals();
      req_valid = '0;
      @(posedge sdr_clk);
      @(negedge sdr_clk);
      sdr_reset = 1'b0;
      model_reset();
      cyc = 0;
      check_outputs();

      // Client 0 read, nelems 15, readend 20 cycles after the start pulse.
      req_valid[0] = 1'b1; req_write[0] = 1'b0;
      req_addr[0 +: 32] = 32'h0; req_nelems[0 +: 30] = 30'd15;
      step();
      acc = m_acc;
      req_valid = '0;
      rs_cnt = 0; rs_cyc = -1; done_c = -1; rv_at_done = 0;
      for (int i = 0; i < 30; i++) begin
         if (sdr_readstart) begin rs_cnt++; rs_cyc = cyc; end
         if (done != 0 && done_c < 0) begin
            done_c = cyc; done_val = done; err_obs = done_err;
            rd_obs = rdata; id_obs = rdata_id; rv_at_done = rdata_valid;
         end
         if (cyc == acc + 10) begin ba_obs = sdr_baseaddr; ne_obs = sdr_nelems; end
         sdr_writeend = 1'b0;
         sdr_readend = (cyc == acc + 21);
         sdr_readdata = sdr_readend ? pat : rand_wide();
         step();
      end
      sdr_readend = 1'b0;
      chk("B_start_count", rs_cnt, 1);
      chk("B_start_offset", rs_cyc - acc, 1);
      chk("B_done_offset", done_c - acc, 22);
      chk("B_done_val", done_val, 2'b01);
      chk("B_done_err", err_obs, 0);
      chk("B_rdata_valid", rv_at_done, 1);
      chk("B_rdata_id", id_obs, 0);
      chk_wide("B_rdata", rd_obs, pat);
      chk("B_baseaddr_wait", ba_obs, 32'h0);
      chk("B_nelems_wait", ne_obs, 15);

      // Both clients continuously valid: client 0 reads, client 1 writes.
      req_write = 2'b10;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[32*i +: 32] = $urandom;
         req_nelems[30*i +: 30] = 30'(1 + $urandom % 64);
         req_wdata[DW*i +: DW] = rand_wide();
      end
      req_valid = 2'b11;
      gq.delete();
      for (int i = 0; i < 400 && gq.size() < 4; i++) begin
         rand_bridge(20, 20);
         step();
         if (last_hs != 0) begin
            gq.push_back(last_hs);
            for (int j = 0; j < NREQ; j++) begin
               if (last_hs[j]) begin
                  req_addr[32*j +: 32] = $urandom;
                  req_nelems[30*j +: 30] = 30'(1 + $urandom % 64);
                  req_wdata[DW*j +: DW] = rand_wide();
               end
            end
         end
      end
      req_valid = '0;
      chk("C_grant_count", gq.size(), 4);
      for (int k = 0; k < gq.size(); k++) begin
         chk("C_grant_order", gq[k], (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      drain(300);

      // Write with spurious readend pulses in WAIT.
      req_write[1] = 1'b1; req_addr[32 +: 32] = 32'h1000;
      req_nelems[30 +: 30] = 30'd8; req_wdata[DW +: DW] = rand_wide();
      req_valid = 2'b10;
      step();
      acc = m_acc;
      req_valid = '0;
      rv_cnt = 0; done_c = -1;
      for (int i = 0; i < 20; i++) begin
         if (rdata_valid) rv_cnt++;
         if (done != 0 && done_c < 0) begin done_c = cyc; done_val = done; err_obs = done_err; end
         sdr_readend = (cyc == acc + 5) || (cyc == acc + 7);
         sdr_writeend = (cyc == acc + 12);
         step();
      end
      sdr_readend = 1'b0; sdr_writeend = 1'b0;
      chk("D_done_offset", done_c - acc, 13);
      chk("D_done_val", done_val, 2'b10);
      chk("D_done_err", err_obs, 0);
      chk("D_rdata_valid_count", rv_cnt, 0);

      // Bridge never responds: watchdog completion.
      req_write[0] = 1'b0; req_nelems[0 +: 30] = 30'd4; req_valid = 2'b01;
      step();
      acc = m_acc;
      req_valid = '0;
      done_c = -1; rv_at_done = 1;
      for (int i = 0; i < 105; i++) begin
         if (done != 0 && done_c < 0) begin
            done_c = cyc; done_val = done; err_obs = done_err; rv_at_done = rdata_valid;
         end
         step();
      end
      chk("E_done_offset", done_c - acc, 102);
      chk("E_done_val", done_val, 2'b01);
      chk("E_done_err", err_obs, 1);
      chk("E_rdata_valid", rv_at_done, 0);

      // Zero-length and oversize requests.
      req_write[1] = 1'b1; req_nelems[30 +: 30] = 30'd0; req_valid = 2'b10;
      step();
      req_valid = '0;
      chk("F0_done", done, 2'b10);
      chk("F0_done_err", done_err, 0);
      chk("F0_writestart", sdr_writestart, 0);
      step();
      step();
      req_write[0] = 1'b0; req_nelems[0 +: 30] = 30'd65; req_valid = 2'b01;
      step();
      req_valid = '0;
      chk("F65_done", done, 2'b01);
      chk("F65_done_err", done_err, 1);
      chk("F65_readstart", sdr_readstart, 0);
      step();
      step();

      // Asynchronous reset five cycles into WAIT.
      req_write[0] = 1'b0; req_nelems[0 +: 30] = 30'd10; req_valid = 2'b01;
      step();
      acc = m_acc;
      req_valid = '0;
      for (int i = 0; i < 20 && cyc < acc + 7; i++) step();
      sdr_reset = 1'b1;
      req_valid = 2'b11;
      #1;
      reset_literals();
      model_reset();
      @(posedge sdr_clk);
      @(negedge sdr_clk);
      sdr_reset = 1'b0;
      req_valid = '0;
      cyc++;
      check_outputs();
      dn_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         sdr_readend = 1'b1;
         step();
         if (done != 0) dn_cnt++;
      end
      sdr_readend = 1'b0;
      chk("G_done_after_reset", dn_cnt, 0);

      // Randomised traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         for (int j = 0; j < NREQ; j++) begin
            if ($urandom % 4 == 0) randomize_client(j);
         end
         rand_bridge(10, 10);
         step();
      end
      req_valid = '0;
      drain(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
